spi_engine_splitter: RTL and testbench
======================================

SPI_ENGINE_SPLITTER -- requirements
Module: spi_engine_splitter

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of sdo/sdi/sync data words.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 sel  input  1  downstream engine select (0 = m0, 1 = m1); sampled only at transaction start.
REQ-005 s_cmd_valid/s_cmd_ready/s_cmd_data  in/out/in  1/1/16  upstream command stream.
REQ-006 s_sdo_valid/s_sdo_ready/s_sdo_data  in/out/in  1/1/DATA_WIDTH  upstream SDO stream.
REQ-007 s_sdi_valid/s_sdi_ready/s_sdi_data  out/in/out  1/1/DATA_WIDTH  upstream SDI stream.
REQ-008 s_sync_valid/s_sync_ready/s_sync  out/in/out  1/1/8  upstream sync stream.
REQ-009 mN_cmd_valid/mN_cmd_ready/mN_cmd_data (N=0,1)  out/in/out  1/1/16  downstream command stream per engine.
REQ-010 mN_sdo_valid/mN_sdo_ready/mN_sdo_data  out/in/out  1/1/DATA_WIDTH  downstream SDO per engine.
REQ-011 mN_sdi_valid/mN_sdi_ready/mN_sdi_data  in/out/in  1/1/DATA_WIDTH  downstream SDI per engine.
REQ-012 mN_sync_valid/mN_sync_ready/mN_sync  in/out/in  1/1/8  downstream sync per engine.
REQ-013 busy  output  1  high in ACTIVE state.
REQ-014 active_sel  output  1  registered engine select of current/last transaction.
REQ-015 xfer_count  output  8  count of completed transactions.

Function
REQ-016 States: IDLE, ACTIVE; a transaction is routed in full to one engine.
REQ-017 IDLE: all valid outputs to both masters and upstream 0; s_cmd_ready, s_sdo_ready 0; mN_sdi_ready, mN_sync_ready 0.
REQ-018 IDLE -> ACTIVE on the cycle after s_cmd_valid=1 is sampled; active_sel <= sel on the same edge.
REQ-019 sel changes while ACTIVE are ignored.
REQ-020 ACTIVE: m<active_sel>_cmd_valid = s_cmd_valid, s_cmd_ready = m<active_sel>_cmd_ready; same pass-through for sdo.
REQ-021 ACTIVE: s_sdi_valid/s_sdi_data from m<active_sel>_sdi; m<active_sel>_sdi_ready = s_sdi_ready; same for sync.
REQ-022 Non-selected master: all valid/ready outputs 0 at all times; cmd/sdo data broadcast to both masters unconditionally.
REQ-023 All handshake paths combinational: zero-cycle latency, no buffering; no beat created, dropped or duplicated.
REQ-024 ACTIVE -> IDLE on the edge where s_sync_valid=1 and s_sync_ready=1; that beat completes in full.
REQ-025 Same edge as REQ-024: xfer_count increments by 1, wrapping 255 -> 0.
REQ-026 Sync handshake and new s_cmd_valid in the same cycle: sync wins, block enters IDLE; new transaction starts from IDLE (earliest ACTIVE two edges later), sampling sel then.
REQ-027 SDI beats from the non-selected engine are never forwarded or acknowledged; that engine stalls.
REQ-028 busy = (state == ACTIVE), registered.

Reset
REQ-029 resetn=0 asynchronously forces state IDLE, active_sel 0, xfer_count 0, busy 0; all handshake outputs 0 while resetn=0 (follows from REQ-017).
REQ-030 Reset mid-transaction aborts it: no sync issued upstream, xfer_count not incremented; first post-reset transaction starts from IDLE per REQ-018.

Verification
REQ-031 sel=1, s_cmd_valid=1 with cmd 0x2001 from IDLE -> 0 cycles: all m*_cmd_valid 0; next cycle m1_cmd_valid=1, m1_cmd_data=0x2001, m0_cmd_valid=0, busy=1, active_sel=1.
REQ-032 ACTIVE on m0; toggle sel every cycle, send 4 cmds + 4 SDO beats 0xA5.. -> all 8 beats on m0 in order, none on m1.
REQ-033 m0 returns sync 0x3C with s_sync_ready=0 for 3 cycles, then 1 -> s_sync=0x3C held 3 cycles; busy falls on the handshake edge; xfer_count 0 -> 1.
REQ-034 Sync handshake with s_cmd_valid=1, sel=1 same cycle -> IDLE 1 cycle, then ACTIVE with active_sel=1; m0 receives no extra cmd.
REQ-035 256 complete transactions -> xfer_count returns to 0; m1_sdi_valid=1 during m0 transaction -> s_sdi_valid=0, m1_sdi_ready=0.
REQ-036 resetn pulsed low mid-transaction (between cmd beats) -> immediately busy=0, all valids 0, xfer_count=0, active_sel=0; next transaction routes per sampled sel.

Source files
------------

// File: rtl/spi_engine_splitter.sv
// Routes one SPI engine transaction (cmd/sdo out, sdi/sync back) to one of two downstream engines.
// Engine choice is latched at transaction start; the upstream sync handshake ends the transaction.
module spi_engine_splitter #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  sel,

  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [15:0]           s_cmd_data,
  input  logic                  s_sdo_valid,
  output logic                  s_sdo_ready,
  input  logic [DATA_WIDTH-1:0] s_sdo_data,
  output logic                  s_sdi_valid,
  input  logic                  s_sdi_ready,
  output logic [DATA_WIDTH-1:0] s_sdi_data,
  output logic                  s_sync_valid,
  input  logic                  s_sync_ready,
  output logic [7:0]            s_sync,

  output logic                  m0_cmd_valid,
  input  logic                  m0_cmd_ready,
  output logic [15:0]           m0_cmd_data,
  output logic                  m0_sdo_valid,
  input  logic                  m0_sdo_ready,
  output logic [DATA_WIDTH-1:0] m0_sdo_data,
  input  logic                  m0_sdi_valid,
  output logic                  m0_sdi_ready,
  input  logic [DATA_WIDTH-1:0] m0_sdi_data,
  input  logic                  m0_sync_valid,
  output logic                  m0_sync_ready,
  input  logic [7:0]            m0_sync,

  output logic                  m1_cmd_valid,
  input  logic                  m1_cmd_ready,
  output logic [15:0]           m1_cmd_data,
  output logic                  m1_sdo_valid,
  input  logic                  m1_sdo_ready,
  output logic [DATA_WIDTH-1:0] m1_sdo_data,
  input  logic                  m1_sdi_valid,
  output logic                  m1_sdi_ready,
  input  logic [DATA_WIDTH-1:0] m1_sdi_data,
  input  logic                  m1_sync_valid,
  output logic                  m1_sync_ready,
  input  logic [7:0]            m1_sync,

  output logic                  busy,
  output logic                  active_sel,
  output logic [7:0]            xfer_count
);

  typedef enum logic {StIdle, StActive} state_e;

  state_e     state_q;
  logic       active_sel_q;
  logic       busy_q;
  logic [7:0] xfer_count_q;

  logic route0, route1, sync_hs;

  // Routing enables are zero in IDLE, which gates every valid/ready path.
  assign route0  = (state_q == StActive) & ~active_sel_q;
  assign route1  = (state_q == StActive) &  active_sel_q;
  assign sync_hs = s_sync_valid & s_sync_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      active_sel_q <= 1'b0;
      busy_q       <= 1'b0;
      xfer_count_q <= 8'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (s_cmd_valid) begin
            state_q      <= StActive;
            active_sel_q <= sel;
            busy_q       <= 1'b1;
          end
        end
        StActive: begin
          if (sync_hs) begin
            state_q      <= StIdle;
            busy_q       <= 1'b0;
            xfer_count_q <= xfer_count_q + 8'd1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign m0_cmd_valid = route0 & s_cmd_valid;
  assign m1_cmd_valid = route1 & s_cmd_valid;
  assign s_cmd_ready  = (route0 & m0_cmd_ready) | (route1 & m1_cmd_ready);
  assign m0_cmd_data  = s_cmd_data;
  assign m1_cmd_data  = s_cmd_data;

  assign m0_sdo_valid = route0 & s_sdo_valid;
  assign m1_sdo_valid = route1 & s_sdo_valid;
  assign s_sdo_ready  = (route0 & m0_sdo_ready) | (route1 & m1_sdo_ready);
  assign m0_sdo_data  = s_sdo_data;
  assign m1_sdo_data  = s_sdo_data;

  assign s_sdi_valid  = (route0 & m0_sdi_valid) | (route1 & m1_sdi_valid);
  assign s_sdi_data   = active_sel_q ? m1_sdi_data : m0_sdi_data;
  assign m0_sdi_ready = route0 & s_sdi_ready;
  assign m1_sdi_ready = route1 & s_sdi_ready;

  assign s_sync_valid  = (route0 & m0_sync_valid) | (route1 & m1_sync_valid);
  assign s_sync        = active_sel_q ? m1_sync : m0_sync;
  assign m0_sync_ready = route0 & s_sync_ready;
  assign m1_sync_ready = route1 & s_sync_ready;

  assign busy       = busy_q;
  assign active_sel = active_sel_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_spi_engine_splitter.sv
// Scoreboard bench for spi_engine_splitter: expected beats are queued per destination when driven
// and popped when a handshake is observed on the matching port.
module tb_spi_engine_splitter;

  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic sel = 1'b0;

  logic s_cmd_valid = 1'b0, s_cmd_ready;
  logic [15:0] s_cmd_data = '0;
  logic s_sdo_valid = 1'b0, s_sdo_ready;
  logic [DW-1:0] s_sdo_data = '0;
  logic s_sdi_valid, s_sdi_ready = 1'b0;
  logic [DW-1:0] s_sdi_data;
  logic s_sync_valid, s_sync_ready = 1'b0;
  logic [7:0] s_sync;

  logic m0_cmd_valid, m0_cmd_ready = 1'b1;
  logic [15:0] m0_cmd_data;
  logic m0_sdo_valid, m0_sdo_ready = 1'b1;
  logic [DW-1:0] m0_sdo_data;
  logic m0_sdi_valid = 1'b0, m0_sdi_ready;
  logic [DW-1:0] m0_sdi_data = '0;
  logic m0_sync_valid = 1'b0, m0_sync_ready;
  logic [7:0] m0_sync = '0;

  logic m1_cmd_valid, m1_cmd_ready = 1'b1;
  logic [15:0] m1_cmd_data;
  logic m1_sdo_valid, m1_sdo_ready = 1'b1;
  logic [DW-1:0] m1_sdo_data;
  logic m1_sdi_valid = 1'b0, m1_sdi_ready;
  logic [DW-1:0] m1_sdi_data = '0;
  logic m1_sync_valid = 1'b0, m1_sync_ready;
  logic [7:0] m1_sync = '0;

  logic busy, active_sel;
  logic [7:0] xfer_count;

  spi_engine_splitter #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .resetn(resetn), .sel(sel),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data),
    .s_sdo_valid(s_sdo_valid), .s_sdo_ready(s_sdo_ready), .s_sdo_data(s_sdo_data),
    .s_sdi_valid(s_sdi_valid), .s_sdi_ready(s_sdi_ready), .s_sdi_data(s_sdi_data),
    .s_sync_valid(s_sync_valid), .s_sync_ready(s_sync_ready), .s_sync(s_sync),
    .m0_cmd_valid(m0_cmd_valid), .m0_cmd_ready(m0_cmd_ready), .m0_cmd_data(m0_cmd_data),
    .m0_sdo_valid(m0_sdo_valid), .m0_sdo_ready(m0_sdo_ready), .m0_sdo_data(m0_sdo_data),
    .m0_sdi_valid(m0_sdi_valid), .m0_sdi_ready(m0_sdi_ready), .m0_sdi_data(m0_sdi_data),
    .m0_sync_valid(m0_sync_valid), .m0_sync_ready(m0_sync_ready), .m0_sync(m0_sync),
    .m1_cmd_valid(m1_cmd_valid), .m1_cmd_ready(m1_cmd_ready), .m1_cmd_data(m1_cmd_data),
    .m1_sdo_valid(m1_sdo_valid), .m1_sdo_ready(m1_sdo_ready), .m1_sdo_data(m1_sdo_data),
    .m1_sdi_valid(m1_sdi_valid), .m1_sdi_ready(m1_sdi_ready), .m1_sdi_data(m1_sdi_data),
    .m1_sync_valid(m1_sync_valid), .m1_sync_ready(m1_sync_ready), .m1_sync(m1_sync),
    .busy(busy), .active_sel(active_sel), .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_cmd0[$], q_cmd1[$], q_sdo0[$], q_sdo1[$], q_sdi[$], q_sync[$];
  logic        model_busy = 1'b0;
  logic        model_sel = 1'b0;
  logic [7:0]  model_cnt = 8'd0;
  logic        toggle_en = 1'b0;
  logic        hs_cmd, hs_sdo, hs_sdi, hs_sync;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sample handshakes mid-cycle, score them, then step to just after the next rising edge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    hs_cmd  = s_cmd_valid & s_cmd_ready;
    hs_sdo  = s_sdo_valid & s_sdo_ready;
    hs_sdi  = s_sdi_valid & s_sdi_ready;
    hs_sync = s_sync_valid & s_sync_ready;
    if (m0_cmd_valid & m0_cmd_ready) begin
      check_eq("m0_cmd_expected", 32'(q_cmd0.size() != 0), 32'd1);
      if (q_cmd0.size() != 0) begin e = q_cmd0.pop_front(); check_eq("m0_cmd_data", 32'(m0_cmd_data), e); end
    end
    if (m1_cmd_valid & m1_cmd_ready) begin
      check_eq("m1_cmd_expected", 32'(q_cmd1.size() != 0), 32'd1);
      if (q_cmd1.size() != 0) begin e = q_cmd1.pop_front(); check_eq("m1_cmd_data", 32'(m1_cmd_data), e); end
    end
    if (m0_sdo_valid & m0_sdo_ready) begin
      check_eq("m0_sdo_expected", 32'(q_sdo0.size() != 0), 32'd1);
      if (q_sdo0.size() != 0) begin e = q_sdo0.pop_front(); check_eq("m0_sdo_data", 32'(m0_sdo_data), e); end
    end
    if (m1_sdo_valid & m1_sdo_ready) begin
      check_eq("m1_sdo_expected", 32'(q_sdo1.size() != 0), 32'd1);
      if (q_sdo1.size() != 0) begin e = q_sdo1.pop_front(); check_eq("m1_sdo_data", 32'(m1_sdo_data), e); end
    end
    if (hs_sdi) begin
      check_eq("sdi_expected", 32'(q_sdi.size() != 0), 32'd1);
      if (q_sdi.size() != 0) begin e = q_sdi.pop_front(); check_eq("sdi_data", 32'(s_sdi_data), e); end
    end
    if (hs_sync) begin
      check_eq("sync_expected", 32'(q_sync.size() != 0), 32'd1);
      if (q_sync.size() != 0) begin e = q_sync.pop_front(); check_eq("sync_data", 32'(s_sync), e); end
    end
    @(posedge clk);
    #1;
    if (toggle_en) sel = ~sel;
  endtask

  task automatic put_cmd(input logic [15:0] d);
    if (!model_busy) begin model_busy = 1'b1; model_sel = sel; end
    if (model_sel) q_cmd1.push_back(32'(d)); else q_cmd0.push_back(32'(d));
    s_cmd_valid = 1'b1;
    s_cmd_data  = d;
    hs_cmd = 1'b0;
    for (int n = 0; n < 50 && !hs_cmd; n++) cycle();
    s_cmd_valid = 1'b0;
    check_eq("cmd_accepted", 32'(hs_cmd), 32'd1);
  endtask

  task automatic put_sdo(input logic [DW-1:0] d);
    if (model_sel) q_sdo1.push_back(32'(d)); else q_sdo0.push_back(32'(d));
    s_sdo_valid = 1'b1;
    s_sdo_data  = d;
    hs_sdo = 1'b0;
    for (int n = 0; n < 50 && !hs_sdo; n++) cycle();
    s_sdo_valid = 1'b0;
    check_eq("sdo_accepted", 32'(hs_sdo), 32'd1);
  endtask

  task automatic do_sync(input logic [7:0] v);
    q_sync.push_back(32'(v));
    if (model_sel) begin m1_sync_valid = 1'b1; m1_sync = v; end
    else begin m0_sync_valid = 1'b1; m0_sync = v; end
    s_sync_ready = 1'b1;
    hs_sync = 1'b0;
    for (int n = 0; n < 50 && !hs_sync; n++) cycle();
    m0_sync_valid = 1'b0;
    m1_sync_valid = 1'b0;
    s_sync_ready  = 1'b0;
    check_eq("sync_accepted", 32'(hs_sync), 32'd1);
    model_busy = 1'b0;
    model_cnt  = model_cnt + 8'd1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_active_sel", 32'(active_sel), 32'd0);
    check_eq("rst_xfer_count", 32'(xfer_count), 32'd0);
    check_eq("rst_valids", 32'({m0_cmd_valid, m1_cmd_valid, s_cmd_ready, s_sync_valid}), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();

    // Transaction start latency: cmd held in IDLE, forwarded to m1 one edge later.
    sel = 1'b1; s_cmd_valid = 1'b1; s_cmd_data = 16'h2001;
    model_busy = 1'b1; model_sel = 1'b1; q_cmd1.push_back(32'h2001);
    #1;
    check_eq("start_m1_valid_idle", 32'(m1_cmd_valid), 32'd0);
    check_eq("start_m0_valid_idle", 32'(m0_cmd_valid), 32'd0);
    check_eq("start_cmd_ready_idle", 32'(s_cmd_ready), 32'd0);
    cycle();
    check_eq("start_m1_valid", 32'(m1_cmd_valid), 32'd1);
    check_eq("start_m1_data", 32'(m1_cmd_data), 32'h2001);
    check_eq("start_m0_valid", 32'(m0_cmd_valid), 32'd0);
    check_eq("start_busy", 32'(busy), 32'd1);
    check_eq("start_active_sel", 32'(active_sel), 32'd1);
    cycle();
    s_cmd_valid = 1'b0;
    do_sync(8'h11);
    check_eq("xfer_after_first", 32'(xfer_count), 32'(model_cnt));

    // sel toggles every cycle while a transaction is routed to m0.
    sel = 1'b0;
    put_cmd(16'h0100);
    toggle_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      put_cmd(16'h0101 + 16'(i));
      put_sdo(8'hA5 + 8'(i));
    end
    toggle_en = 1'b0;
    check_eq("toggle_active_sel", 32'(active_sel), 32'd0);

    // Sync stalled upstream for 3 cycles, then accepted.
    m0_sync_valid = 1'b1; m0_sync = 8'h3C; s_sync_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("sync_hold_valid", 32'(s_sync_valid), 32'd1);
      check_eq("sync_hold_data", 32'(s_sync), 32'h3C);
      check_eq("sync_hold_m0_ready", 32'(m0_sync_ready), 32'd0);
      cycle();
    end
    s_sync_ready = 1'b1;
    q_sync.push_back(32'h3C);
    #1;
    check_eq("sync_busy_before", 32'(busy), 32'd1);
    cycle();
    m0_sync_valid = 1'b0; s_sync_ready = 1'b0;
    model_busy = 1'b0; model_cnt = model_cnt + 8'd1;
    check_eq("sync_busy_after", 32'(busy), 32'd0);
    check_eq("sync_xfer_count", 32'(xfer_count), 32'(model_cnt));

    // Sync and a new cmd in the same cycle: sync wins, new transaction goes to m1.
    sel = 1'b0;
    put_cmd(16'h0200);
    m0_cmd_ready = 1'b0;
    m0_sync_valid = 1'b1; m0_sync = 8'h77; s_sync_ready = 1'b1;
    q_sync.push_back(32'h77);
    s_cmd_valid = 1'b1; s_cmd_data = 16'h1234; sel = 1'b1;
    q_cmd1.push_back(32'h1234);
    cycle();
    m0_sync_valid = 1'b0; s_sync_ready = 1'b0; m0_cmd_ready = 1'b1;
    model_cnt = model_cnt + 8'd1;
    check_eq("race_idle_busy", 32'(busy), 32'd0);
    check_eq("race_idle_m0_valid", 32'(m0_cmd_valid), 32'd0);
    cycle();
    check_eq("race_busy", 32'(busy), 32'd1);
    check_eq("race_active_sel", 32'(active_sel), 32'd1);
    cycle();
    s_cmd_valid = 1'b0;
    model_busy = 1'b1; model_sel = 1'b1;
    do_sync(8'h78);

    // SDI from m0 forwarded; m1 SDI blocked and stalled.
    sel = 1'b0;
    put_cmd(16'h0300);
    m0_sdi_valid = 1'b1; m0_sdi_data = 8'h5A; s_sdi_ready = 1'b1;
    m1_sdi_valid = 1'b1; m1_sdi_data = 8'hC3;
    q_sdi.push_back(32'h5A);
    #1;
    check_eq("sdi_data_m0", 32'(s_sdi_data), 32'h5A);
    check_eq("sdi_m0_ready", 32'(m0_sdi_ready), 32'd1);
    check_eq("sdi_m1_ready", 32'(m1_sdi_ready), 32'd0);
    cycle();
    m0_sdi_valid = 1'b0;
    #1;
    check_eq("sdi_m1_blocked_valid", 32'(s_sdi_valid), 32'd0);
    check_eq("sdi_m1_blocked_ready", 32'(m1_sdi_ready), 32'd0);
    cycle();
    m1_sdi_valid = 1'b0; s_sdi_ready = 1'b0;
    do_sync(8'h01);
    check_eq("sdi_xfer_count", 32'(xfer_count), 32'(model_cnt));

    // Asynchronous reset between cmd beats of an m1 transaction.
    sel = 1'b1;
    put_cmd(16'h0400);
    #3;
    resetn = 1'b0; s_cmd_valid = 1'b1; s_cmd_data = 16'h0401; m1_sync_valid = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_active_sel", 32'(active_sel), 32'd0);
    check_eq("arst_xfer_count", 32'(xfer_count), 32'd0);
    check_eq("arst_valids", 32'({m0_cmd_valid, m1_cmd_valid, s_cmd_ready, s_sync_valid,
                                 m1_sync_ready}), 32'd0);
    s_cmd_valid = 1'b0; m1_sync_valid = 1'b0;
    model_busy = 1'b0; model_cnt = 8'd0;
    @(posedge clk); #1;
    resetn = 1'b1;
    cycle();

    sel = 1'b0;
    put_cmd(16'h0BEE);
    check_eq("post_rst_active_sel", 32'(active_sel), 32'd0);
    do_sync(8'h02);
    check_eq("post_rst_xfer_count", 32'(xfer_count), 32'd1);

    // 255 more complete transactions wrap the counter back to zero.
    for (int i = 0; i < 255; i++) begin
      sel = 1'(i);
      put_cmd(16'h8000 + 16'(i));
      do_sync(8'(i));
    end
    check_eq("wrap_xfer_count", 32'(xfer_count), 32'(model_cnt));
    check_eq("wrap_is_zero", 32'(xfer_count), 32'd0);

    check_eq("q_empty", 32'(q_cmd0.size() + q_cmd1.size() + q_sdo0.size() + q_sdo1.size()
                            + q_sdi.size() + q_sync.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
